// File: rtl/ttt_pkg.sv
// ---------------------------------------------------------------------------
// ttt_pkg
// Shared types and constants for the tic-tac-toe board blocks.
//   box_state_e : per-box occupancy code (EMPTY / X / O; 2'b11 reserved)
//   NO_BOX      : cursor value meaning "no empty box exists"
//   CELL/PITCH/OFFSET : LED-matrix geometry of one box footprint
// ---------------------------------------------------------------------------
package ttt_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    X     = 2'b01,
    O     = 2'b10
  } box_state_e;

  localparam int          NUM_BOXES = 9;
  localparam logic [3:0]  NO_BOX    = 4'd9;

  // A box occupies CELL pixels, boxes repeat every PITCH pixels, and the
  // first box starts OFFSET pixels in from the matrix edge.
  localparam int CELL   = 4;
  localparam int PITCH  = 5;
  localparam int OFFSET = 1;

endpackage

// File: rtl/next_empty_finder.sv
// ---------------------------------------------------------------------------
// next_empty_finder
// Combinational forward search for the first empty box at or after a start
// index, wrapping from box 8 back to box 0.
//   empty_mask [8:0] in  : bit k set when box k is empty
//   start      [3:0] in  : first index to examine (0-8)
//   idx        [3:0] out : first empty index found (NO_BOX when none)
//   none             out : no box is empty at all
// ---------------------------------------------------------------------------
module next_empty_finder
  import ttt_pkg::*;
(
  input  logic [8:0] empty_mask,
  input  logic [3:0] start,
  output logic [3:0] idx,
  output logic       none
);

  logic       found;
  logic [4:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = NO_BOX;
    cand  = 5'd0;
    for (int i = 0; i < NUM_BOXES; i++) begin
      // start + i stays below 18, so one conditional subtract is a full mod 9
      cand = 5'(start) + 5'(i);
      if (cand >= 5'(NUM_BOXES)) begin
        cand = cand - 5'(NUM_BOXES);
      end
      if (!found && empty_mask[cand[3:0]]) begin
        found = 1'b1;
        idx   = cand[3:0];
      end
    end
    none = ~found;
  end

endmodule

// File: rtl/box_selector.sv
// ---------------------------------------------------------------------------
// box_selector
// Cursor over the empty boxes of the 3x3 board, drawn as a green 4x4 block
// on the 16x16 LED matrix.
//   clk              in  : system clock
//   reset            in  : asynchronous active-low reset
//   next             in  : advance request (level; rising edge = one press)
//   out0..out8 [1:0] in  : box states, row-major; non-zero = occupied
//   GrnPixels [15:0][15:0] out : green plane [row][col], lit on box curBox
//   curBox     [3:0] out : selected box 0-8, or 9 when the board is full
// ---------------------------------------------------------------------------
module box_selector
  import ttt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              next,
  input  logic [1:0]        out0,
  input  logic [1:0]        out1,
  input  logic [1:0]        out2,
  input  logic [1:0]        out3,
  input  logic [1:0]        out4,
  input  logic [1:0]        out5,
  input  logic [1:0]        out6,
  input  logic [1:0]        out7,
  input  logic [1:0]        out8,
  output logic [15:0][15:0] GrnPixels,
  output logic [3:0]        curBox
);

  logic [3:0] cur_box_q, cur_box_d;
  logic       next_dly_q, next_dly_d;   // registered copy of next

  logic [1:0] box_state [NUM_BOXES];
  logic [8:0] empty_mask;
  logic       press;
  logic       cur_valid;
  logic       cur_empty;
  logic [3:0] search_start;
  logic [3:0] found_idx;
  logic       no_empty;

  assign box_state[0] = out0;
  assign box_state[1] = out1;
  assign box_state[2] = out2;
  assign box_state[3] = out3;
  assign box_state[4] = out4;
  assign box_state[5] = out5;
  assign box_state[6] = out6;
  assign box_state[7] = out7;
  assign box_state[8] = out8;

  generate
    for (genvar gi = 0; gi < NUM_BOXES; gi++) begin : g_empty
      assign empty_mask[gi] = (box_state[gi] == EMPTY);
    end
  endgenerate

  assign press     = next & ~next_dly_q;
  assign cur_valid = (cur_box_q < NO_BOX);

  always_comb begin
    cur_empty = 1'b0;
    if (cur_valid) begin
      cur_empty = empty_mask[cur_box_q];
    end
  end

  // Re-seek and advance both search from the box after the cursor; from
  // NO_BOX the search restarts at box 0. Re-seek and advance share it.
  assign search_start = (!cur_valid || cur_box_q == 4'd8) ? 4'd0 : cur_box_q + 4'd1;

  next_empty_finder u_finder (
    .empty_mask (empty_mask),
    .start      (search_start),
    .idx        (found_idx),
    .none       (no_empty)
  );

  // Priority: full board, then re-seek off an occupied/invalid cursor (which
  // swallows any simultaneous press), then a press, else hold. A sole empty
  // cursor box is found again by the wrapped search, so it stays put.
  always_comb begin
    next_dly_d = next;
    cur_box_d  = cur_box_q;
    if (no_empty) begin
      cur_box_d = NO_BOX;
    end else if (!cur_empty) begin
      cur_box_d = found_idx;
    end else if (press) begin
      cur_box_d = found_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_box_q  <= 4'd0;
      next_dly_q <= 1'b0;
    end else begin
      cur_box_q  <= cur_box_d;
      next_dly_q <= next_dly_d;
    end
  end

  assign curBox = cur_box_q;

  // Pixel decoder: a pixel is lit when its row and its column both fall in
  // the footprint of the current box.
  logic [1:0]  box_row, box_col;
  logic [4:0]  row_lo, col_lo;
  logic [15:0] row_hit, col_hit;

  always_comb begin
    box_row = 2'(cur_box_q / 4'd3);
    box_col = 2'(cur_box_q % 4'd3);
    row_lo  = 5'(PITCH) * {3'b000, box_row} + 5'(OFFSET);
    col_lo  = 5'(PITCH) * {3'b000, box_col} + 5'(OFFSET);
  end

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_hit
      assign row_hit[gi] = cur_valid && (5'(gi) >= row_lo) && (5'(gi) < row_lo + 5'(CELL));
      assign col_hit[gi] = cur_valid && (5'(gi) >= col_lo) && (5'(gi) < col_lo + 5'(CELL));
    end
    for (genvar gi = 0; gi < 16; gi++) begin : g_row
      for (genvar gj = 0; gj < 16; gj++) begin : g_col
        assign GrnPixels[gi][gj] = row_hit[gi] & col_hit[gj];
      end
    end
  endgenerate

endmodule

// File: tb/tb_box_selector.sv
module tb_box_selector;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              next = 1'b0;
  logic [1:0]        b [9];
  logic [15:0][15:0] GrnPixels;
  logic [3:0]        curBox;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference state
  int exp_cur  = 0;
  bit prev_nxt = 1'b0;

  always #5 clk = ~clk;

  box_selector dut (
    .clk       (clk),
    .reset     (reset),
    .next      (next),
    .out0      (b[0]),
    .out1      (b[1]),
    .out2      (b[2]),
    .out3      (b[3]),
    .out4      (b[4]),
    .out5      (b[5]),
    .out6      (b[6]),
    .out7      (b[7]),
    .out8      (b[8]),
    .GrnPixels (GrnPixels),
    .curBox    (curBox)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit [8:0] empties();
    bit [8:0] m;
    for (int k = 0; k < 9; k++) m[k] = (b[k] == 2'b00);
    return m;
  endfunction

  // Cursor rules written directly from the board description.
  function automatic int model_next(input int cur, input bit pressed, input bit [8:0] em);
    int first;
    int s;
    if (em == 9'd0) return 9;
    s = (cur == 9) ? 0 : (cur + 1) % 9;
    first = -1;
    for (int i = 0; i < 9; i++) begin
      if (first < 0 && em[(s + i) % 9]) first = (s + i) % 9;
    end
    if (cur == 9 || !em[cur]) return first;
    if (pressed) return first;
    return cur;
  endfunction

  // Expected green plane: box k covers rows 5*(k/3)+1..+4, cols 5*(k%3)+1..+4.
  function automatic logic [255:0] pix_of(input int k);
    logic [255:0] p;
    p = '0;
    if (k < 9) begin
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 16; c++)
          if (r >= 5*(k/3)+1 && r <= 5*(k/3)+4 && c >= 5*(k%3)+1 && c <= 5*(k%3)+4)
            p[r*16 + c] = 1'b1;
    end
    return p;
  endfunction

  // Called at a falling edge with inputs already set for the coming rising edge.
  task automatic cycle();
    exp_cur  = model_next(exp_cur, next && !prev_nxt, empties());
    prev_nxt = next;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    $display("cyc %0d next=%0b empty=%b cur=%0d exp=%0d", cyc, next, empties(), curBox, exp_cur);
    check("cur", curBox, exp_cur);
    check("pix", GrnPixels, pix_of(exp_cur));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    next  = 1'b0;
    #1;
    exp_cur  = 0;
    prev_nxt = 1'b0;
    $display("reset asserted cur=%0d", curBox);
    check("rst_cur", curBox, 0);
    check("rst_pix", GrnPixels, pix_of(0));
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic press();
    next = 1'b1;
    cycle();
    next = 1'b0;
    cycle();
  endtask

  task automatic set_board(input logic [17:0] v);
    for (int k = 0; k < 9; k++) b[k] = v[17 - 2*k -: 2];
  endtask

  logic [255:0] plan_pix;

  initial begin
    set_board(18'd0);

    // Empty board: 11 presses step 1..8,0,1,2
    do_reset();
    press();
    check("plan_first_cur", curBox, 1);
    plan_pix = '0;
    for (int r = 1; r <= 4; r++)
      for (int c = 6; c <= 9; c++) plan_pix[r*16 + c] = 1'b1;
    check("plan_first_pix", GrnPixels, plan_pix);
    for (int i = 0; i < 10; i++) press();
    check("plan_empty_end", curBox, 2);

    // Board {0,2,5 = X}
    set_board(18'b01_00_01_00_00_01_00_00_00);
    do_reset();
    cycle();
    check("plan_b2_seek", curBox, 1);
    for (int i = 0; i < 7; i++) press();
    check("plan_b2_end", curBox, 3);

    // Board {0,4,8 = O; 2,5 = X}
    set_board(18'b10_00_01_00_10_01_00_00_10);
    do_reset();
    cycle();
    check("plan_b3_seek", curBox, 1);
    for (int i = 0; i < 6; i++) press();
    check("plan_b3_end", curBox, 6);

    // One empty box, then full
    set_board(18'b10_10_01_10_10_01_10_00_10);
    cycle();
    check("plan_one_left", curBox, 7);
    press();
    press();
    check("plan_one_hold", curBox, 7);
    b[7] = 2'b10;
    cycle();
    check("plan_full_cur", curBox, 9);
    check("plan_full_pix", GrnPixels, 256'd0);

    // next held high 5 cycles: single advance
    set_board(18'd0);
    do_reset();
    next = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    next = 1'b0;
    cycle();
    check("plan_held", curBox, 1);

    // curBox = 4 then box 4 taken, no press
    do_reset();
    for (int i = 0; i < 4; i++) press();
    check("plan_at4", curBox, 4);
    b[4] = 2'b01;
    cycle();
    check("plan_reseek5", curBox, 5);

    // Randomized phase
    set_board(18'd0);
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_reset();
      end
      if ($urandom_range(0, 39) == 0) begin
        set_board(18'd0);
      end else if ($urandom_range(0, 5) == 0) begin
        b[$urandom_range(0, 8)] = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      end
      next = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
